// File: rtl/brent_kung_sub_pipe.sv
// -----------------------------------------------------------------------------
// brent_kung_sub_pipe
//
// Inverse of the 12-bit Brent-Kung pair adder. Given the (WIDTH+1)-bit sum S
// and one WIDTH-bit operand A, this block recovers the other operand
// B = S - A through a two-stage valid/ready pipeline:
//   stage 1 : low-half subtract, produces a borrow
//   stage 2 : high-half subtract with that borrow, flags out-of-range results
//
// Parameters
//   WIDTH  operand width (even, >= 4); the sum is WIDTH+1 bits
//   HALF   low-half split point, derived as WIDTH/2 (not for override)
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   input beat present
//   in_ready   block can accept a beat this cycle (combinational on out_ready)
//   in_sum     sum S, WIDTH+1 bits
//   in_a       known operand A
//   out_valid  result beat present
//   out_ready  downstream accepts the result
//   out_b      recovered operand, (S - A) mod 2^WIDTH
//   out_err    S < A, or S - A does not fit in WIDTH bits
//   err_cnt    saturating count of error beats transferred out
//              (present only when BK_SUB_ERR_COUNT_EN is defined)
//
// Build option
//   BK_SUB_ERR_COUNT_EN  adds err_cnt and its saturating counter
// -----------------------------------------------------------------------------
module brent_kung_sub_pipe #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH:0]   in_sum,
    input  logic [WIDTH-1:0] in_a,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_b,
    output logic             out_err
`ifdef BK_SUB_ERR_COUNT_EN
    ,
    output logic [7:0]       err_cnt
`endif
);

    localparam int HALF = WIDTH / 2;

    // Stage 1 state
    logic            s1_valid;
    logic [HALF-1:0] s1_lo;
    logic            s1_borrow;
    logic [HALF:0]   s1_hi_s;   // S[WIDTH:HALF]
    logic [HALF-1:0] s1_hi_a;   // A[WIDTH-1:HALF]

    // Stage 2 state (s2_valid drives out_valid)
    logic            s2_valid;

    // Handshake / advance
    logic s1_load;
    logic s2_load;

    assign s2_load  = s1_valid & (~s2_valid | out_ready);
    assign in_ready = ~s1_valid | s2_load;
    assign s1_load  = in_valid & in_ready;

    // Low half: S_lo + ~A_lo + 1; the borrow is the inverted carry out.
    logic [HALF:0] lo_sum;
    assign lo_sum = {1'b0, in_sum[HALF-1:0]} + {1'b0, ~in_a[HALF-1:0]}
                  + (HALF+1)'(1);

    // High half at HALF+2 bits: bit HALF+1 is the sign of the full difference,
    // bit HALF set means the result needs bit WIDTH.
    logic [HALF+1:0] hi_diff;
    assign hi_diff = {1'b0, s1_hi_s} - {2'b00, s1_hi_a}
                   - {{(HALF+1){1'b0}}, s1_borrow};

    // NOTE: data registers are reset along with the valid bits because out_b
    // and out_err are observable and must read 0 during reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_lo     <= '0;
            s1_borrow <= 1'b0;
            s1_hi_s   <= '0;
            s1_hi_a   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values of its neighbours, independent of statement order.
            if (s1_load) begin
                s1_lo     <= lo_sum[HALF-1:0];
                s1_borrow <= ~lo_sum[HALF];
                s1_hi_s   <= in_sum[WIDTH:HALF];
                s1_hi_a   <= in_a[WIDTH-1:HALF];
            end
            if (s1_load)
                s1_valid <= 1'b1;
            else if (s2_load)
                s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            out_b    <= '0;
            out_err  <= 1'b0;
        end else begin
            if (s2_load) begin
                out_b   <= {hi_diff[HALF-1:0], s1_lo};
                out_err <= hi_diff[HALF+1] | hi_diff[HALF];
            end
            if (s2_load)
                s2_valid <= 1'b1;
            else if (out_ready)
                s2_valid <= 1'b0;
        end
    end

    assign out_valid = s2_valid;

`ifdef BK_SUB_ERR_COUNT_EN
    // Counts error beats only on the transfer, so a stalled beat counts once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_cnt <= 8'd0;
        else if (s2_valid && out_ready && out_err && (err_cnt != 8'hFF))
            err_cnt <= err_cnt + 8'd1;
    end
`endif

endmodule

// File: tb/tb_brent_kung_sub_pipe.sv
// -----------------------------------------------------------------------------
// tb_brent_kung_sub_pipe
//
// Self-checking bench for brent_kung_sub_pipe. Expected results come from an
// integer model of S - A, pushed to a queue on each accepted input and popped
// by a monitor on each output transfer.
// -----------------------------------------------------------------------------
module tb_brent_kung_sub_pipe;

    localparam int WIDTH = 12;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH:0]   in_sum;
    logic [WIDTH-1:0] in_a;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_b;
    logic             out_err;
`ifdef BK_SUB_ERR_COUNT_EN
    logic [7:0]       err_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int pushed = 0;
    int popped = 0;

    // {err, b}
    logic [WIDTH:0] exp_q[$];

    brent_kung_sub_pipe #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sum    (in_sum),
        .in_a      (in_a),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_b     (out_b),
        .out_err   (out_err)
`ifdef BK_SUB_ERR_COUNT_EN
        ,
        .err_cnt   (err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH:0] model(input logic [WIDTH:0] s,
                                             input logic [WIDTH-1:0] a);
        int d;
        logic err;
        d   = int'(s) - int'(a);
        err = (d < 0) || (d > (1 << WIDTH) - 1);
        return {err, d[WIDTH-1:0]};
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [WIDTH:0] s, input logic [WIDTH-1:0] a,
                        output int stalls);
        in_valid = 1'b1;
        in_sum   = s;
        in_a     = a;
        stalls   = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(model(s, a));
                pushed++;
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
            stalls++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("send_timeout", 32'(in_ready), 32'(1));
    endtask

    // Scoreboard monitor: the transfer happens at the next rising edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("stale_beat", 32'(out_valid), 32'(0));
            end else begin
                logic [WIDTH:0] e;
                e = exp_q.pop_front();
                check("sb_b", 32'(out_b), 32'(e[WIDTH-1:0]));
                check("sb_err", 32'(out_err), 32'(e[WIDTH]));
                popped++;
            end
        end
    end

    task automatic drain(input string tag);
        for (int k = 0; k < 100 && exp_q.size() != 0; k++) begin
            @(posedge clk);
            #1;
        end
        check(tag, 32'(exp_q.size()), 32'(0));
        check({tag, "_count"}, 32'(popped), 32'(pushed));
    endtask

    initial begin
        int st;
        logic [WIDTH:0]   vs[4];
        logic [WIDTH-1:0] va[4];
        logic [WIDTH:0]   hold_exp;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sum    = '0;
        in_a      = '0;
        out_ready = 1'b0;

        // Reset state
        #3;
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_out_b", 32'(out_b), 32'(0));
        check("rst_out_err", 32'(out_err), 32'(0));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'(1));

        // First beat with latency check
        out_ready = 1'b1;
        send(13'h0FFF, 12'h800, st);
        check("lat_n1_valid", 32'(out_valid), 32'(0));
        @(posedge clk);
        #1;
        check("lat_n2_valid", 32'(out_valid), 32'(1));
        check("lat_n2_b", 32'(out_b), 32'(12'h7FF));
        check("lat_n2_err", 32'(out_err), 32'(0));
        @(posedge clk);
        #1;

        // Borrow across halves, negative, overflow
        vs[0] = 13'h1000; va[0] = 12'h001;
        vs[1] = 13'h0005; va[1] = 12'h006;
        vs[2] = 13'h1FFE; va[2] = 12'h000;
        vs[3] = 13'h1000; va[3] = 12'h000;
        for (int i = 0; i < 4; i++) send(vs[i], va[i], st);
        for (int i = 0; i < 10; i++)
            send(13'($urandom_range(0, 8191)), 12'($urandom_range(0, 4095)), st);
        drain("dir_drain");

        // Backpressure: two beats fill the pipe, the third stalls
        out_ready = 1'b0;
        hold_exp  = model(13'h0123, 12'h045);
        send(13'h0123, 12'h045, st);
        check("bp_b1_stall", 32'(st), 32'(0));
        send(13'h0FED, 12'hCBA, st);
        check("bp_b2_stall", 32'(st), 32'(0));
        in_valid = 1'b1;
        in_sum   = 13'h1555;
        in_a     = 12'hAAA;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_in_ready", 32'(in_ready), 32'(0));
            check("bp_hold_valid", 32'(out_valid), 32'(1));
            check("bp_hold_b", 32'(out_b), 32'(hold_exp[WIDTH-1:0]));
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(13'h1555, 12'hAAA, st);
        check("bp_release_accept", 32'(st), 32'(0));
        send(13'h0800, 12'h7FF, st);
        send(13'h0000, 12'h000, st);
        for (int i = 0; i < 8; i++) begin
            send(13'($urandom_range(0, 8191)), 12'($urandom_range(0, 4095)), st);
            check("stream_stall", 32'(st), 32'(0));
        end
        drain("bp_drain");
        check("idle_valid", 32'(out_valid), 32'(0));

        // Reset with two beats in flight
        out_ready = 1'b0;
        send(13'h0100, 12'h001, st);
        send(13'h0200, 12'h002, st);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'(0));
        check("midrst_out_b", 32'(out_b), 32'(0));
        exp_q.delete();
        pushed = 0;
        popped = 0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_in_ready", 32'(in_ready), 32'(1));
        repeat (5) @(posedge clk);
        #1;
        check("midrst_no_stale", 32'(out_valid), 32'(0));

`ifdef BK_SUB_ERR_COUNT_EN
        check("cnt_reset", 32'(err_cnt), 32'(0));
        out_ready = 1'b0;
        send(13'h0005, 12'h006, st);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("cnt_held", 32'(err_cnt), 32'(0));
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("cnt_once", 32'(err_cnt), 32'(1));
        repeat (2) @(posedge clk);
        #1;
        check("cnt_no_double", 32'(err_cnt), 32'(1));
        for (int i = 0; i < 299; i++) send(13'h1FFF, 12'h000, st);
        drain("cnt_drain");
        check("cnt_saturate", 32'(err_cnt), 32'(255));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
